serial_byte_collector: RTL and testbench
========================================

Name: serial_byte_collector

Overview:
- Downstream consumer of the serial bit stream produced by the 8-bit shift stage (single data bit `di`, qualified by `wr`).
- Assembles bits MSB-first into bytes and buffers completed bytes in a small FIFO.
- Presents the FIFO through a valid/ready interface to the next stage, with overflow reporting.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- di  input  1  serial data bit; sampled only when wr=1.
- wr  input  1  bit strobe; one bit accepted per cycle with wr=1.
- flush  input  1  synchronous clear of bit assembler and FIFO.
- byte_data  output  8  head-of-FIFO byte; valid only when byte_valid=1.
- byte_valid  output  1  FIFO non-empty.
- byte_ready  input  1  consumer accepts head when byte_valid and byte_ready are both 1.
- level  output  CNT_W  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a completed byte is dropped.

Behaviour:
- Reset: async assertion clears every register at once. byte_valid=0, level=0, overflow=0, byte_data=0, bit count=0, shift reg=0, FSM=S_DATA.
- Bit assembly: on clk with wr=1, the shift register becomes {sr[6:0], di}, so the first bit received ends up as bit 7. bit_cnt increments 0..7.
- Byte completion: when wr=1 and bit_cnt=7, the completed byte {sr[6:0], di} is pushed that same edge and bit_cnt wraps to 0.
- Push/visibility latency: a pushed byte appears at byte_data/byte_valid on the next cycle. There is no fall-through.
- Pop: when byte_valid and byte_ready are both 1, the head advances on the clock edge.
- Full, push only: byte dropped, overflow set to 1, level unchanged.
- Full, push and pop same cycle: push accepted, level stays DEPTH, overflow not set.
- Empty, pop attempted: ignored, since byte_valid=0.
- Read/write pointers: log2(DEPTH) bits, natural wrap-around; level tracks occupancy separately.
- flush: highest synchronous priority. Clears FIFO, bit_cnt and FSM state; any push or pop in that cycle is discarded; overflow is cleared too.
- wr=0: assembler holds its state indefinitely; a partial byte persists.
- byte_data when empty: holds the last value and carries no meaning.
- FSM states: S_DATA (collecting bits 0..7); S_PARITY exists only with the optional feature.
- Reset mid-byte: the partial byte is lost and the assembler restarts at bit 0.

Optional Feature:
- Macro: SERIAL_BYTE_COLLECTOR_PARITY_EN.
- With macro defined:
  - A 9th serial bit (even parity over the 8 data bits) follows each byte. FSM goes S_DATA -> S_PARITY after bit 7, and S_PARITY -> S_DATA on the next wr.
  - The byte is pushed only if parity matches; otherwise it is discarded.
  - Extra output parity_err (1 bit) pulses high for exactly one cycle after a mismatched parity bit.
  - flush or rst returns the FSM to S_DATA.
- Without macro: no parity bit, no parity_err port, FSM has only S_DATA.

Decomposition:
- Shared package serial_byte_pkg:
  - typedef byte_t (logic [7:0]).
  - state enum (S_DATA, S_PARITY).
  - localparam BITS_PER_BYTE = 8.
- One sub-module, sbc_fifo: parameterised DEPTH × byte_t synchronous FIFO exposing push, pop, full, empty and level. The top level holds the assembler, FSM and overflow logic.

Test Plan:
- Shift in bits 1,0,1,0,0,1,0,1 with wr=1 on consecutive cycles, byte_ready=0 -> byte_valid rises the cycle after bit 8, byte_data=8'hA5, level=1.
- Same 8 bits with wr toggling 1/0 each cycle -> identical 8'hA5; no extra bytes; bit_cnt unaffected by wr=0 cycles.
- Push DEPTH+1 bytes (8'h01..8'h05, DEPTH=4) with byte_ready=0 -> level=4, overflow=1; pop order gives 8'h01..8'h04, and 8'h05 is absent.
- FIFO full, 5th byte completes in the same cycle byte_ready=1 -> 8'h05 accepted, level stays 4, overflow stays 0.
- Four bits shifted, then rst pulse, then 8 bits of 8'h3C -> single byte 8'h3C; flush with level=3 -> level=0, byte_valid=0 next cycle.
- With SERIAL_BYTE_COLLECTOR_PARITY_EN: send 8'hA5 plus parity 0 -> pushed. Send 8'hA5 plus parity 1 -> not pushed, parity_err high for one cycle.

Source files
------------

// File: rtl/serial_byte_pkg.sv
// Shared types for the serial byte collector: byte type, assembler FSM states
// and the byte geometry constant.
package serial_byte_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    S_DATA   = 1'b0,
    S_PARITY = 1'b1
  } state_t;

  localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/sbc_fifo.sv
// Byte FIFO behind the serial assembler: registered storage, no fall-through,
// pointer wrap-around with a separate occupancy counter.
module sbc_fifo
  import serial_byte_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  byte_t            din,
  output byte_t            dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  byte_t            mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout  = mem[rd_ptr];
  assign empty = (level == '0);
  assign full  = (level == CNT_W'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + CNT_W'(1);
        2'b01:   level <= level - CNT_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/serial_byte_collector.sv
// Collects an MSB-first serial bit stream into bytes and queues them for a
// valid/ready consumer. SERIAL_BYTE_COLLECTOR_PARITY_EN adds an even-parity bit per byte.
module serial_byte_collector
  import serial_byte_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             di,
  input  logic             wr,
  input  logic             flush,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic [CNT_W-1:0] level,
  output logic             overflow
`ifdef SERIAL_BYTE_COLLECTOR_PARITY_EN
  , output logic           parity_err
`endif
);

  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

  byte_t      sr;
  logic [2:0] bit_cnt;
  state_t     state;
  logic       push_req;
  byte_t      push_byte;
  logic       full;
  logic       empty;
  logic       pop_req;

  assign pop_req    = byte_valid & byte_ready;
  assign byte_valid = ~empty;

`ifdef SERIAL_BYTE_COLLECTOR_PARITY_EN
  logic par_ok;

  // Even parity: data ones plus the parity bit must come to an even count.
  assign par_ok = ~(^sr ^ di);

  always_comb begin
    push_req  = wr & ~flush & (state == S_PARITY) & par_ok;
    push_byte = sr;
  end
`else
  always_comb begin
    push_req  = wr & ~flush & (state == S_DATA) & (bit_cnt == LAST_BIT);
    push_byte = {sr[6:0], di};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      bit_cnt  <= '0;
      state    <= S_DATA;
      overflow <= 1'b0;
`ifdef SERIAL_BYTE_COLLECTOR_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (flush) begin
      sr       <= '0;
      bit_cnt  <= '0;
      state    <= S_DATA;
      overflow <= 1'b0;
`ifdef SERIAL_BYTE_COLLECTOR_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (push_req && full && !pop_req) overflow <= 1'b1;
`ifdef SERIAL_BYTE_COLLECTOR_PARITY_EN
      parity_err <= 1'b0;
      if (wr) begin
        case (state)
          S_DATA: begin
            sr      <= {sr[6:0], di};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) state <= S_PARITY;
          end
          default: begin
            state      <= S_DATA;
            parity_err <= ~par_ok;
          end
        endcase
      end
`else
      if (wr) begin
        sr      <= {sr[6:0], di};
        bit_cnt <= bit_cnt + 3'd1;
      end
`endif
    end
  end

  sbc_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push_req),
    .pop   (byte_ready),
    .din   (push_byte),
    .dout  (byte_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_serial_byte_collector.sv
// Directed bench for serial_byte_collector: vector table for the main flows,
// hand sequences for reset-mid-byte, flush and the parity build.
module tb_serial_byte_collector;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             di = 1'b0;
  logic             wr = 1'b0;
  logic             flush = 1'b0;
  logic             byte_ready = 1'b0;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic [CNT_W-1:0] level;
  logic             overflow;
`ifdef SERIAL_BYTE_COLLECTOR_PARITY_EN
  logic             parity_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_byte_collector #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .di         (di),
    .wr         (wr),
    .flush      (flush),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .level      (level),
    .overflow   (overflow)
`ifdef SERIAL_BYTE_COLLECTOR_PARITY_EN
    , .parity_err (parity_err)
`endif
  );

  typedef struct {
    string      nm;
    logic       di;
    logic       wr;
    logic       rdy;
    logic       fl;
    logic       ev;
    logic [7:0] ed;
    int         el;
    logic       eo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic d, input logic w, input logic r, input logic f,
                     input logic ev, input logic [7:0] ed, input int el, input logic eo);
    vec_t v;
    v.nm = nm; v.di = d; v.wr = w; v.rdy = r; v.fl = f;
    v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
    vecs.push_back(v);
  endtask

  // Eight contiguous bits MSB first; bits 7..1 expect the "mid" state, bit 0 the "end" state.
  task automatic add_byte(input string nm, input logic [7:0] b, input logic rdy_last,
                          input logic mv, input logic [7:0] md, input int ml, input logic mo,
                          input logic ev, input logic [7:0] ed, input int el, input logic eo);
    for (int i = 7; i >= 1; i--) add(nm, b[i], 1'b1, 1'b0, 1'b0, mv, md, ml, mo);
    add(nm, b[0], 1'b1, rdy_last, 1'b0, ev, ed, el, eo);
  endtask

  task automatic step_bit(input logic d);
    di = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; di = 1'b0;
  endtask

  task automatic step_idle(input logic r, input logic f);
    byte_ready = r; flush = f;
    @(posedge clk); #1;
    byte_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] c3c;
    a5  = 8'hA5;
    c3c = 8'h3C;

    // Reset state while rst is held.
    #2;
    check("reset_valid", 32'(byte_valid), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    check("reset_data", 32'(byte_data), 32'd0);
`ifdef SERIAL_BYTE_COLLECTOR_PARITY_EN
    check("reset_perr", 32'(parity_err), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

`ifndef SERIAL_BYTE_COLLECTOR_PARITY_EN
    // A: 8'hA5 on consecutive cycles, then pop it.
    add_byte("a5_contig", a5, 1'b0, 0, 8'h00, 0, 0, 1, 8'hA5, 1, 0);
    add("a5_pop", 0, 0, 1, 0, 0, 8'h00, 0, 0);
    // B: same byte with wr toggling; wr=0 cycles carry the inverted bit on di.
    for (int i = 7; i >= 0; i--) begin
      add("a5_toggle", a5[i], 1, 0, 0, (i == 0), 8'hA5, (i == 0) ? 1 : 0, 0);
      add("a5_toggle_idle", ~a5[i], 0, 0, 0, (i == 0), 8'hA5, (i == 0) ? 1 : 0, 0);
    end
    add("a5_toggle_pop", 0, 0, 1, 0, 0, 8'h00, 0, 0);
    // C: five bytes into a 4-deep FIFO, 8'h05 dropped.
    for (int k = 1; k <= 5; k++)
      add_byte("ovf_fill", 8'(k), 1'b0, (k > 1), 8'h01, k - 1, 0,
               1, 8'h01, (k > 4) ? 4 : k, (k == 5));
    add("ovf_pop1", 0, 0, 1, 0, 1, 8'h02, 3, 1);
    add("ovf_pop2", 0, 0, 1, 0, 1, 8'h03, 2, 1);
    add("ovf_pop3", 0, 0, 1, 0, 1, 8'h04, 1, 1);
    add("ovf_pop4", 0, 0, 1, 0, 0, 8'h00, 0, 1);
    add("empty_pop", 0, 0, 1, 0, 0, 8'h00, 0, 1);
    add("flush_ovf", 0, 0, 0, 1, 0, 8'h00, 0, 0);
    // D: full FIFO, 5th byte completes while the head is popped.
    for (int k = 1; k <= 4; k++)
      add_byte("full_fill", 8'(k), 1'b0, (k > 1), 8'h01, k - 1, 0, 1, 8'h01, k, 0);
    add_byte("full_pushpop", 8'h05, 1'b1, 1, 8'h01, 4, 0, 1, 8'h02, 4, 0);
    add("full_pop1", 0, 0, 1, 0, 1, 8'h03, 3, 0);
    add("full_pop2", 0, 0, 1, 0, 1, 8'h04, 2, 0);
    add("full_pop3", 0, 0, 1, 0, 1, 8'h05, 1, 0);
    add("full_pop4", 0, 0, 1, 0, 0, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      di = vecs[i].di; wr = vecs[i].wr; byte_ready = vecs[i].rdy; flush = vecs[i].fl;
      @(posedge clk); #1;
      check({vecs[i].nm, "_valid"}, 32'(byte_valid), 32'(vecs[i].ev));
      check({vecs[i].nm, "_level"}, 32'(level), 32'(vecs[i].el));
      check({vecs[i].nm, "_ovf"}, 32'(overflow), 32'(vecs[i].eo));
      if (vecs[i].ev) check({vecs[i].nm, "_data"}, 32'(byte_data), 32'(vecs[i].ed));
    end
    di = 0; wr = 0; byte_ready = 0; flush = 0;

    // Reset mid-byte: four bits then an async reset pulse between edges.
    for (int i = 0; i < 4; i++) step_bit(1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_level", 32'(level), 32'd0);
    check("rst_mid_valid", 32'(byte_valid), 32'd0);
    #3 rst = 1'b0;
    for (int i = 7; i >= 1; i--) step_bit(c3c[i]);
    check("rst_mid_7bits_level", 32'(level), 32'd0);
    step_bit(c3c[0]);
    check("rst_mid_3c_valid", 32'(byte_valid), 32'd1);
    check("rst_mid_3c_data", 32'(byte_data), 32'h3C);
    check("rst_mid_3c_level", 32'(level), 32'd1);

    // Flush with three bytes queued.
    for (int b = 0; b < 2; b++)
      for (int i = 7; i >= 0; i--) step_bit(1'b0);
    check("flush_pre_level", 32'(level), 32'd3);
    step_idle(1'b0, 1'b1);
    check("flush_level", 32'(level), 32'd0);
    check("flush_valid", 32'(byte_valid), 32'd0);
`else
    // Parity build: 8'hA5 with correct parity 0 is pushed.
    for (int i = 7; i >= 0; i--) step_bit(a5[i]);
    check("par_ok_8bits_level", 32'(level), 32'd0);
    step_bit(1'b0);
    check("par_ok_level", 32'(level), 32'd1);
    check("par_ok_data", 32'(byte_data), 32'hA5);
    check("par_ok_perr", 32'(parity_err), 32'd0);
    step_idle(1'b1, 1'b0);
    check("par_ok_pop_level", 32'(level), 32'd0);
    // Wrong parity 1: dropped with a single-cycle parity_err.
    for (int i = 7; i >= 0; i--) step_bit(a5[i]);
    step_bit(1'b1);
    check("par_bad_level", 32'(level), 32'd0);
    check("par_bad_valid", 32'(byte_valid), 32'd0);
    check("par_bad_perr", 32'(parity_err), 32'd1);
    step_idle(1'b0, 1'b0);
    check("par_bad_perr_clear", 32'(parity_err), 32'd0);
    // Next byte realigns on S_DATA: 8'h3C has four ones, parity 0.
    for (int i = 7; i >= 0; i--) step_bit(c3c[i]);
    step_bit(1'b0);
    check("par_next_level", 32'(level), 32'd1);
    check("par_next_data", 32'(byte_data), 32'h3C);
    check("par_next_ovf", 32'(overflow), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
